aes_fifo: RTL and testbench
===========================

# aes_fifo

- Pairs a 64-bit, four-round substitution–permutation cipher with a ciphertext FIFO.
- Write: encrypts `data` under `key` and pushes the ciphertext.
- Read: pops the oldest ciphertext and decrypts it with the `key` presented at read time.
- A companion combinational checker compares decrypted output against the original plaintext for verification.

## Interface
Parameters:
- DEPTH, 16, FIFO entries (power of two ≥ 2)
- NR, 4, cipher rounds

Ports (`aes_fifo`):
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- data  input  64  plaintext for encryption
- key  input  64  cipher key, used on both write and read
- we  input  1  write strobe: encrypt `data`/`key` and push
- re  input  1  read strobe: pop and decrypt with current `key`
- encrypt_data  output  64  ciphertext of the most recent accepted write
- decrypt_data  output  64  plaintext of the most recent accepted read

Ports (checker `aes_scoreboard`):
- original_data  input  64
- decrypted_data  input  64
- match_result  output  1  1 when the inputs are equal (purely combinational)

## Operation
Cipher (combinational, 64-bit state):
- S-box (4-bit, PRESENT): 0→C 1→5 2→6 3→B 4→9 5→0 6→A 7→D 8→3 9→E A→F B→8 C→4 D→7 E→1 F→2. Inverse for decryption.
- Permutation P: bit j → bit (16·j mod 63) for j<63; bit 63 stays.
- Key schedule:
  - K0 = key.
  - K(i+1) = rotl(Ki, 13) XOR (i+1) in bits [3:0].
  - Generate K0..K(NR).
- Encrypt: for i = 0..NR−1, state = P(S(state XOR Ki)) (S applied to all 16 nibbles); then ciphertext = state XOR K(NR).
- Decrypt: state = ct XOR K(NR); for i = NR−1 down to 0, state = S⁻¹(P⁻¹(state)) XOR Ki.
- Requirement: decrypt(encrypt(x, k), k) = x for all x, k.

FIFO:
- Circular buffer of DEPTH × 64-bit ciphertexts, with read/write pointers and a count of width clog2(DEPTH)+1.
- Keys are not stored; decryption uses `key` at the read cycle.
- we with not full: store encrypt(data, key) at wptr, wptr++ (wraps), encrypt_data ← same value.
- we with full: write dropped; encrypt_data still updates with the ciphertext; count unchanged.
- re with not empty: decrypt_data ← decrypt(mem[rptr], key), rptr++ (wraps).
- re with empty: ignored; decrypt_data holds.
- we and re in the same cycle:
  - Both act; count unchanged.
  - When empty, only the write takes effect and the read is ignored (no bypass).
  - When full, both take effect (the read frees a slot).

## Timing
- Reset (rst=0, asynchronous): pointers, count, encrypt_data and decrypt_data all clear to 0. Memory contents don't care.
- Write latency: encrypt_data is valid the cycle after the edge that sampled we=1.
- Read latency: decrypt_data is valid the cycle after the edge that sampled re=1.
- Outputs hold between accepted operations.
- Reset asserted mid-stream discards all FIFO contents; the first read after reset is treated as empty.
- No ready/valid handshake exists. The user must not read when empty or write when full if data loss matters.

## Structure
- Package `aes_fifo_pkg`: S-box and inverse S-box functions, permutation and inverse functions, key-schedule function, and encrypt/decrypt functions.
- Sub-module `aes_scoreboard`: the combinational comparator.
- Single top `aes_fifo` holding the FIFO and output registers.

## Test plan
- Reset: rst=0 → encrypt_data = decrypt_data = 0. A read immediately after release leaves decrypt_data = 0.
- Single round trip:
  - Write data=0x0123456789ABCDEF, key=0x133457799BBCDFF1 → encrypt_data ≠ data.
  - Read with the same key → decrypt_data = 0x0123456789ABCDEF; match_result = 1.
- Ten random packets, each with a unique key:
  - Write all ten, idle 5 cycles, then read all ten with the matching keys in order.
  - Every decrypt_data equals its plaintext (FIFO order preserved); match_result = 1 each time.
- Wrong key: read with key XOR 1 → decrypt_data ≠ plaintext; match_result = 0.
- Full/wrap:
  - Write DEPTH+1 packets → the extra packet is dropped.
  - Reads return the first DEPTH in order; a further read holds decrypt_data.
  - Refill past the wrap point and verify order.
- Simultaneous we & re with 3 entries: the oldest is returned, the new entry is stored, and count stays 3. Asynchronous reset mid-stream clears everything.

Source files
------------

// File: rtl/aes_fifo_pkg.sv
// Shared cipher primitives: 4-bit S-box layer, bit permutation,
// rotating key schedule and the full encrypt/decrypt datapaths.
package aes_fifo_pkg;

    localparam int MAX_NR = 8;

    typedef logic [63:0]             blk_t;
    typedef logic [MAX_NR:0][63:0]   ksched_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic blk_t sub_layer(input blk_t x);
        blk_t y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
        return y;
    endfunction

    function automatic blk_t inv_sub_layer(input blk_t x);
        blk_t y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        return y;
    endfunction

    // Bit j lands on bit 16*j mod 63; bit 63 is a fixed point.
    function automatic logic [5:0] pdest(input int j);
        int d;
        d = (j == 63) ? 63 : (16 * j) % 63;
        return d[5:0];
    endfunction

    function automatic blk_t perm(input blk_t x);
        blk_t y;
        y = '0;
        for (int j = 0; j < 64; j++) y[pdest(j)] = x[j];
        return y;
    endfunction

    function automatic blk_t inv_perm(input blk_t x);
        blk_t y;
        for (int j = 0; j < 64; j++) y[j] = x[pdest(j)];
        return y;
    endfunction

    function automatic ksched_t key_sched(input blk_t key);
        ksched_t ks;
        ks[0] = key;
        for (int i = 0; i < MAX_NR; i++)
            ks[i+1] = {ks[i][50:0], ks[i][63:51]} ^ {60'd0, 4'(i + 1)};
        return ks;
    endfunction

    function automatic blk_t encrypt(input blk_t pt, input blk_t key, input int nr);
        ksched_t ks;
        blk_t s;
        ks = key_sched(key);
        s  = pt;
        for (int i = 0; i < MAX_NR; i++)
            if (i < nr) s = perm(sub_layer(s ^ ks[i]));
        return s ^ ks[nr];
    endfunction

    function automatic blk_t decrypt(input blk_t ct, input blk_t key, input int nr);
        ksched_t ks;
        blk_t s;
        ks = key_sched(key);
        s  = ct ^ ks[nr];
        for (int i = MAX_NR - 1; i >= 0; i--)
            if (i < nr) s = inv_sub_layer(inv_perm(s)) ^ ks[i];
        return s;
    endfunction

endpackage

// File: rtl/aes_scoreboard.sv
// Combinational equality check of recovered plaintext against the
// original; used alongside aes_fifo to confirm round trips.
module aes_scoreboard (
    input  logic [63:0] original_data,
    input  logic [63:0] decrypted_data,
    output logic        match_result
);

    assign match_result = (original_data == decrypted_data);

endmodule

// File: rtl/aes_fifo.sv
// Ciphertext FIFO: encrypts on write, decrypts with the read-time key
// on read. Keys are never stored.
module aes_fifo
    import aes_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int NR    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data,
    input  logic [63:0] key,
    input  logic        we,
    input  logic        re,
    output logic [63:0] encrypt_data,
    output logic [63:0] decrypt_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   enc_q, enc_d;
    logic [63:0]   dec_q, dec_d;
    logic [63:0]   ct;
    logic          full, empty, do_wr, do_rd;

    assign ct    = encrypt(data, key, NR);
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign do_rd = re && !empty;
    // A read in the same cycle frees the slot a full FIFO would refuse.
    assign do_wr = we && (!full || do_rd);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q + CW'(do_wr) - CW'(do_rd);
        enc_d  = enc_q;
        dec_d  = dec_q;
        if (do_wr) wptr_d = wptr_q + 1'b1;
        if (do_rd) rptr_d = rptr_q + 1'b1;
        if (we)    enc_d  = ct;
        if (do_rd) dec_d  = decrypt(mem_q[rptr_q], key, NR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            enc_q  <= '0;
            dec_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            enc_q  <= enc_d;
            dec_q  <= dec_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= ct;
    end

    assign encrypt_data = enc_q;
    assign decrypt_data = dec_q;

endmodule

// File: tb/tb_aes_fifo.sv
// Randomised bench for aes_fifo with an independent queue-based model
// and a from-scratch cipher reference.
module tb_aes_fifo;

    localparam int DEPTH = 16;
    localparam int NR    = 4;

    localparam bit [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] data = '0;
    logic [63:0] key = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [63:0] encrypt_data, decrypt_data;
    logic [63:0] orig = '0;
    logic        match;

    int n_chk  = 0;
    int n_fail = 0;

    bit [63:0] mq [$];
    bit [63:0] pq [$];
    bit [63:0] kq [$];
    bit [63:0] m_enc_q = '0;
    bit [63:0] m_dec_q = '0;

    aes_fifo #(.DEPTH(DEPTH), .NR(NR)) dut (
        .clk(clk), .rst(rst), .data(data), .key(key), .we(we), .re(re),
        .encrypt_data(encrypt_data), .decrypt_data(decrypt_data)
    );

    aes_scoreboard u_sb (
        .original_data(orig), .decrypted_data(decrypt_data),
        .match_result(match)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int dst(input int j);
        return (j == 63) ? 63 : (16 * j) % 63;
    endfunction

    function automatic void rkeys(input bit [63:0] k, output bit [63:0] rk [NR+1]);
        rk[0] = k;
        for (int i = 0; i < NR; i++)
            rk[i+1] = ((rk[i] << 13) | (rk[i] >> 51)) ^ 64'(i + 1);
    endfunction

    function automatic bit [63:0] m_enc(input bit [63:0] x, input bit [63:0] k);
        bit [63:0] rk [NR+1];
        bit [63:0] s, t, p;
        rkeys(k, rk);
        s = x;
        for (int r = 0; r < NR; r++) begin
            s = s ^ rk[r];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
            p = '0;
            for (int j = 0; j < 64; j++) p[dst(j)] = t[j];
            s = p;
        end
        return s ^ rk[NR];
    endfunction

    function automatic bit [63:0] m_dec(input bit [63:0] c, input bit [63:0] k);
        bit [63:0] rk [NR+1];
        bit [63:0] s, u, v;
        rkeys(k, rk);
        s = c ^ rk[NR];
        for (int r = NR - 1; r >= 0; r--) begin
            for (int j = 0; j < 64; j++) u[j] = s[dst(j)];
            for (int n = 0; n < 16; n++)
                for (int q = 0; q < 16; q++)
                    if (SB[q] == u[4*n +: 4]) v[4*n +: 4] = 4'(q);
            s = v ^ rk[r];
        end
        return s;
    endfunction

    task automatic cyc(input logic w, input logic r, input logic [63:0] d, input logic [63:0] k);
        bit rd_ok, wr_ok;
        we = w; re = r; data = d; key = k;
        @(posedge clk);
        #1;
        rd_ok = r && (mq.size() != 0);
        wr_ok = w && (mq.size() < DEPTH || rd_ok);
        if (rd_ok) begin
            m_dec_q = m_dec(mq.pop_front(), k);
            orig    = pq.pop_front();
            void'(kq.pop_front());
        end
        if (w) m_enc_q = m_enc(d, k);
        if (wr_ok) begin
            mq.push_back(m_enc_q);
            pq.push_back(d);
            kq.push_back(k);
        end
        we = 1'b0; re = 1'b0;
        #1;
        chk("enc", encrypt_data, m_enc_q);
        chk("dec", decrypt_data, m_dec_q);
        chk("match", 64'(match), 64'(m_dec_q == orig));
    endtask

    task automatic wr_rand();
        cyc(1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic rd_next();
        bit [63:0] k;
        k = (kq.size() != 0) ? kq[0] : {$urandom, $urandom};
        cyc(1'b0, 1'b1, '0, k);
    endtask

    initial begin
        bit [63:0] pt, k;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_enc", encrypt_data, 64'd0);
        chk("rst_dec", decrypt_data, 64'd0);
        rst = 1'b1;
        rd_next();
        chk("rd_empty", decrypt_data, 64'd0);

        pt = 64'h0123456789ABCDEF;
        k  = 64'h133457799BBCDFF1;
        cyc(1'b1, 1'b0, pt, k);
        chk("ct_ne_pt", 64'(encrypt_data != pt), 64'd1);
        cyc(1'b0, 1'b1, '0, k);
        chk("rt_dec", decrypt_data, pt);
        chk("rt_match", 64'(match), 64'd1);

        for (int i = 0; i < 10; i++) wr_rand();
        repeat (5) cyc(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            pt = pq[0];
            rd_next();
            chk("ten_dec", decrypt_data, pt);
            chk("ten_match", 64'(match), 64'd1);
        end

        pt = {$urandom, $urandom};
        k  = {$urandom, $urandom};
        cyc(1'b1, 1'b0, pt, k);
        cyc(1'b0, 1'b1, '0, k ^ 64'd1);
        chk("wk_ne", 64'(decrypt_data != pt), 64'd1);
        chk("wk_match", 64'(match), 64'd0);

        for (int i = 0; i < DEPTH + 1; i++) wr_rand();
        chk("full_depth", 64'(mq.size()), 64'(DEPTH));
        cyc(1'b1, 1'b1, {$urandom, $urandom}, kq[0]);
        for (int i = 0; i < DEPTH; i++) rd_next();
        k = decrypt_data;
        rd_next();
        chk("hold", decrypt_data, k);

        for (int i = 0; i < 10; i++) wr_rand();
        for (int i = 0; i < 10; i++) rd_next();

        for (int i = 0; i < 3; i++) wr_rand();
        pt = pq[0];
        cyc(1'b1, 1'b1, {$urandom, $urandom}, kq[0]);
        chk("sim_old", decrypt_data, pt);
        for (int i = 0; i < 3; i++) rd_next();
        k = decrypt_data;
        rd_next();
        chk("sim_cnt3", decrypt_data, k);

        cyc(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});

        for (int i = 0; i < 300; i++) begin
            bit w, r;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            if (r && kq.size() != 0 && $urandom_range(0, 9) != 0)
                cyc(w, r, {$urandom, $urandom}, kq[0]);
            else
                cyc(w, r, {$urandom, $urandom}, {$urandom, $urandom});
        end

        wr_rand();
        wr_rand();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mrst_enc", encrypt_data, 64'd0);
        chk("mrst_dec", decrypt_data, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        mq.delete(); pq.delete(); kq.delete();
        m_enc_q = '0; m_dec_q = '0; orig = '0;
        rd_next();
        chk("mrst_rd", decrypt_data, 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
